sipo_align_deser: RTL

//  Parametrised serial-to-parallel deserializer with comma-based word alignment for the PCIe 8b/10b receive path.

---
 rtl/sipo_align_deser.sv | 113 +++++++++++
 1 files changed

// File: rtl/sipo_align_deser.sv
// sipo_align_deser: LSB-first serial-to-parallel deserializer with K28.5
// comma alignment and lock tracking. It sits between the serial line and
// the 10b/8b decoder.
module sipo_align_deser #(
  parameter int unsigned     WIDTH       = 10,
  parameter logic [WIDTH-1:0] COMMA_P    = 10'h17C,
  parameter logic [WIDTH-1:0] COMMA_N    = 10'h283,
  parameter int unsigned     LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             locked,
  output logic             comma_det
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned MW = $clog2(LOSS_THRESH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [MW-1:0] LOSS_M   = MW'(LOSS_THRESH);

  typedef enum logic {HUNT, SYNC} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_nx;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             comma_det_q, comma_det_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]    mis_cnt_q, mis_cnt_d;
  logic             match;
  logic [MW-1:0]    mis_inc;

  // Next-state: shift, comma match, word framing and lock/loss decisions.
  always_comb begin
    sr_nx        = {sin, sr_q[WIDTH-1:1]};
    match        = (sr_nx == COMMA_P) || (sr_nx == COMMA_N);
    mis_inc      = mis_cnt_q + MW'(1);
    state_d      = state_q;
    sr_d         = sr_q;
    pout_d       = pout_q;
    pout_valid_d = 1'b0;
    comma_det_d  = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (sin_en) begin
      sr_d        = sr_nx;
      comma_det_d = match;
      case (state_q)
        HUNT: begin
          if (match) begin
            state_d      = SYNC;
            bit_cnt_d    = '0;
            pout_d       = sr_nx;
            pout_valid_d = 1'b1;
            mis_cnt_d    = '0;
          end
        end
        SYNC: begin
          if (bit_cnt_q == LAST_BIT) begin
            pout_d       = sr_nx;
            pout_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (match) mis_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (match) begin
              // Losing lock does not re-align on this bit; the hunt
              // restarts with the next shift.
              if (mis_inc == LOSS_M) begin
                state_d   = HUNT;
                mis_cnt_d = '0;
              end else begin
                mis_cnt_d = mis_inc;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
      bit_cnt_q    <= '0;
      mis_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      comma_det_q  <= comma_det_d;
      bit_cnt_q    <= bit_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign comma_det  = comma_det_q;
  assign locked     = (state_q == SYNC);

endmodule
